// File: rtl/reorder_buffer.sv
// reorder_buffer: dual-issue in-order retirement buffer freeing old physical regs; ROB_RETIRE_CNT_EN adds retired_total
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 6,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid_1,
    input  logic              alloc_valid_2,
    input  logic              alloc_has_rd_1,
    input  logic              alloc_has_rd_2,
    input  logic [PREG_W-1:0] alloc_oldrd_1,
    input  logic [PREG_W-1:0] alloc_oldrd_2,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_idx_1,
    output logic [IDX_W-1:0]  alloc_idx_2,
    input  logic              complete_valid_a,
    input  logic              complete_valid_b,
    input  logic [IDX_W-1:0]  complete_idx_a,
    input  logic [IDX_W-1:0]  complete_idx_b,
    output logic [63:0]       free_regs,
    output logic [1:0]        retire_count,
`ifdef ROB_RETIRE_CNT_EN
    output logic [31:0]       retired_total,
`endif
    output logic              empty,
    output logic              full
);
    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    logic [IDX_W-1:0]  head, tail, head_1;
    logic [IDX_W:0]    count;
    logic [DEPTH-1:0]  valid, done, has_rd;
    logic [PREG_W-1:0] oldrd [DEPTH];
    logic              a1, a2, r0, r1;
    logic [63:0]       free_next;

    assign alloc_ready = (DEPTH_C - count) >= (IDX_W+1)'(2);
    assign a1          = alloc_ready & alloc_valid_1;
    assign a2          = alloc_ready & alloc_valid_2;
    assign alloc_idx_1 = tail;
    assign alloc_idx_2 = tail + IDX_W'(alloc_valid_1);
    assign head_1      = head + IDX_W'(1);
    assign r0          = valid[head] & done[head];
    assign r1          = r0 & valid[head_1] & done[head_1];
    assign empty       = count == '0;
    assign full        = count == DEPTH_C;

    // one-hot mask of old mappings released by this cycle's retirements; preg 0 is never freed
    always_comb begin
        free_next = '0;
        if (r0 && has_rd[head] && oldrd[head] != '0) free_next[oldrd[head]] = 1'b1;
        if (r1 && has_rd[head_1] && oldrd[head_1] != '0) free_next[oldrd[head_1]] = 1'b1;
    end

    // pointers, occupancy, valid/done flags and the retire pulse outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            valid        <= '0;
            done         <= '0;
            free_regs    <= '0;
            retire_count <= '0;
        end else begin
            if (complete_valid_a && valid[complete_idx_a]) done[complete_idx_a] <= 1'b1;
            if (complete_valid_b && valid[complete_idx_b]) done[complete_idx_b] <= 1'b1;
            if (r0) begin
                valid[head] <= 1'b0;
                done[head]  <= 1'b0;
            end
            if (r1) begin
                valid[head_1] <= 1'b0;
                done[head_1]  <= 1'b0;
            end
            if (a1) begin
                valid[alloc_idx_1] <= 1'b1;
                done[alloc_idx_1]  <= 1'b0;
            end
            if (a2) begin
                valid[alloc_idx_2] <= 1'b1;
                done[alloc_idx_2]  <= 1'b0;
            end
            tail         <= tail + IDX_W'(a1) + IDX_W'(a2);
            head         <= head + IDX_W'(r0) + IDX_W'(r1);
            count        <= count + (IDX_W+1)'(a1) + (IDX_W+1)'(a2) - (IDX_W+1)'(r0) - (IDX_W+1)'(r1);
            free_regs    <= free_next;
            retire_count <= 2'(r0) + 2'(r1);
        end
    end

    // entry payload needs no reset: it is only read while the entry is valid
    always_ff @(posedge clk) begin
        if (a1) begin
            has_rd[alloc_idx_1] <= alloc_has_rd_1;
            oldrd[alloc_idx_1]  <= alloc_oldrd_1;
        end
        if (a2) begin
            has_rd[alloc_idx_2] <= alloc_has_rd_2;
            oldrd[alloc_idx_2]  <= alloc_oldrd_2;
        end
    end

`ifdef ROB_RETIRE_CNT_EN
    // running count of retired instructions, wraps modulo 2^32
    always_ff @(posedge clk) begin
        if (reset) retired_total <= '0;
        else retired_total <= retired_total + 32'(r0) + 32'(r1);
    end
`endif
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed stimulus with a retire scoreboard for reorder_buffer
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alloc_valid_1 = 1'b0, alloc_valid_2 = 1'b0;
    logic        alloc_has_rd_1 = 1'b0, alloc_has_rd_2 = 1'b0;
    logic [5:0]  alloc_oldrd_1 = '0, alloc_oldrd_2 = '0;
    logic        alloc_ready;
    logic [3:0]  alloc_idx_1, alloc_idx_2;
    logic        complete_valid_a = 1'b0, complete_valid_b = 1'b0;
    logic [3:0]  complete_idx_a = '0, complete_idx_b = '0;
    logic [63:0] free_regs;
    logic [1:0]  retire_count;
    logic        empty, full;
`ifdef ROB_RETIRE_CNT_EN
    logic [31:0] retired_total;
    int          exp_total = 0;
`endif

    reorder_buffer dut (
        .clk(clk), .reset(reset),
        .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
        .alloc_has_rd_1(alloc_has_rd_1), .alloc_has_rd_2(alloc_has_rd_2),
        .alloc_oldrd_1(alloc_oldrd_1), .alloc_oldrd_2(alloc_oldrd_2),
        .alloc_ready(alloc_ready), .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
        .complete_valid_a(complete_valid_a), .complete_valid_b(complete_valid_b),
        .complete_idx_a(complete_idx_a), .complete_idx_b(complete_idx_b),
        .free_regs(free_regs), .retire_count(retire_count),
`ifdef ROB_RETIRE_CNT_EN
        .retired_total(retired_total),
`endif
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] fr;
        logic [1:0]  rc;
    } exp_t;

    exp_t       q[$];
    exp_t       e_m;
    int         n_cmp = 0, n_err = 0;
    logic [3:0] last_i1, last_i2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic logic [63:0] bit_of(input int i);
        return 64'(1) << i;
    endfunction

    task automatic push(input logic [63:0] fr, input logic [1:0] rc);
        q.push_back('{fr: fr, rc: rc});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic alloc(input logic v1, input logic h1, input logic [5:0] o1,
                         input logic v2, input logic h2, input logic [5:0] o2);
        alloc_valid_1 = v1; alloc_has_rd_1 = h1; alloc_oldrd_1 = o1;
        alloc_valid_2 = v2; alloc_has_rd_2 = h2; alloc_oldrd_2 = o2;
        #1;
        last_i1 = alloc_idx_1;
        last_i2 = alloc_idx_2;
        tick();
        alloc_valid_1 = 1'b0;
        alloc_valid_2 = 1'b0;
    endtask

    task automatic comp(input logic va, input logic [3:0] ia, input logic vb, input logic [3:0] ib);
        complete_valid_a = va; complete_idx_a = ia;
        complete_valid_b = vb; complete_idx_b = ib;
        tick();
        complete_valid_a = 1'b0;
        complete_valid_b = 1'b0;
    endtask

    // monitor: every retire pulse must match the oldest expected retire
    always @(negedge clk) begin
        if (retire_count != 2'd0 || free_regs != 64'd0) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_retire: got free_regs=%h retire_count=%0d expected no retire", free_regs, retire_count);
            end else begin
                e_m = q.pop_front();
`ifdef ROB_RETIRE_CNT_EN
                exp_total += int'(e_m.rc);
`endif
                if ({free_regs, retire_count} !== {e_m.fr, e_m.rc}) begin
                    n_err++;
                    $display("FAIL retire: got free_regs=%h retire_count=%0d expected free_regs=%h retire_count=%0d",
                             free_regs, retire_count, e_m.fr, e_m.rc);
                end
            end
        end
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_ready", 64'(alloc_ready), 64'd1);
        chk("rst_retire_count", 64'(retire_count), 64'd0);
        chk("rst_free_regs", free_regs, 64'd0);
`ifdef ROB_RETIRE_CNT_EN
        chk("rst_total", 64'(retired_total), 64'd0);
`endif
        // two-wide alloc, complete, retire
        push(bit_of(5) | bit_of(9), 2'd2);
        alloc(1, 1, 6'd5, 1, 1, 6'd9);
        chk("t1_idx1", 64'(last_i1), 64'd0);
        chk("t1_idx2", 64'(last_i2), 64'd1);
        comp(1, 4'd0, 1, 4'd1);
        tick();
        chk("t1_empty", 64'(empty), 64'd1);
        // out-of-order completion waits for the head
        do_reset();
        alloc(1, 0, 6'd0, 1, 1, 6'd12);
        chk("t2_idx1", 64'(last_i1), 64'd0);
        chk("t2_idx2", 64'(last_i2), 64'd1);
        comp(0, 4'd0, 1, 4'd1);
        tick();
        tick();
        chk("t2_no_retire", 64'(retire_count), 64'd0);
        chk("t2_not_empty", 64'(empty), 64'd0);
        push(bit_of(12), 2'd2);
        comp(1, 4'd0, 0, 4'd0);
        tick();
        chk("t2_empty", 64'(empty), 64'd1);
        // fill to 15, blocked alloc, retire during block
        for (int k = 0; k < 14; k += 2) alloc(1, 1, 6'(20 + k), 1, 1, 6'(21 + k));
        alloc(1, 1, 6'd34, 0, 0, 6'd0);
        chk("t3_ready_15", 64'(alloc_ready), 64'd0);
        chk("t3_full_15", 64'(full), 64'd0);
        chk("t3_tail", 64'(alloc_idx_1), 64'd1);
        alloc_valid_1 = 1; alloc_has_rd_1 = 1; alloc_oldrd_1 = 6'd60;
        alloc_valid_2 = 1; alloc_has_rd_2 = 1; alloc_oldrd_2 = 6'd61;
        tick();
        chk("t3_blocked_full", 64'(full), 64'd0);
        chk("t3_blocked_tail", 64'(alloc_idx_1), 64'd1);
        push(bit_of(20) | bit_of(21), 2'd2);
        comp(1, 4'd2, 1, 4'd3);
        tick();
        chk("t3_ready_13", 64'(alloc_ready), 64'd1);
        chk("t3_tail_kept", 64'(alloc_idx_1), 64'd1);
        alloc_valid_1 = 0;
        alloc_valid_2 = 0;
        for (int k = 2; k < 14; k += 2) begin
            push(bit_of(20 + k) | bit_of(21 + k), 2'd2);
            comp(1, 4'((2 + k) % 16), 1, 4'((3 + k) % 16));
        end
        push(bit_of(34), 2'd1);
        comp(1, 4'd0, 0, 4'd0);
        tick();
        tick();
        chk("t3_empty", 64'(empty), 64'd1);
        // wrap around the end of the ring
        do_reset();
        for (int p = 0; p < 7; p++) begin
            push(64'd0, 2'd2);
            alloc(1, 0, 6'd0, 1, 0, 6'd0);
            comp(1, 4'(2 * p), 1, 4'(2 * p + 1));
        end
        tick();
        tick();
        alloc(1, 1, 6'd40, 1, 1, 6'd41);
        chk("t4_idx_14", 64'(last_i1), 64'd14);
        chk("t4_idx_15", 64'(last_i2), 64'd15);
        alloc(1, 1, 6'd42, 1, 1, 6'd43);
        chk("t4_idx_0", 64'(last_i1), 64'd0);
        chk("t4_idx_1", 64'(last_i2), 64'd1);
        push(bit_of(40) | bit_of(41), 2'd2);
        push(bit_of(42) | bit_of(43), 2'd2);
        comp(1, 4'd14, 1, 4'd15);
        comp(1, 4'd0, 1, 4'd1);
        tick();
        tick();
        chk("t4_empty", 64'(empty), 64'd1);
        // completion to an unallocated tag is dropped
        do_reset();
        alloc(1, 0, 6'd0, 1, 0, 6'd0);
        alloc(1, 0, 6'd0, 1, 0, 6'd0);
        alloc(1, 0, 6'd0, 1, 0, 6'd0);
        alloc(1, 0, 6'd0, 0, 0, 6'd0);
        push(64'd0, 2'd2);
        push(64'd0, 2'd2);
        push(64'd0, 2'd2);
        push(64'd0, 2'd1);
        comp(1, 4'd0, 1, 4'd1);
        comp(1, 4'd2, 1, 4'd3);
        comp(1, 4'd4, 1, 4'd5);
        comp(1, 4'd6, 0, 4'd0);
        tick();
        tick();
        chk("t5_empty_before", 64'(empty), 64'd1);
        comp(1, 4'd7, 0, 4'd0);
        alloc(1, 1, 6'd50, 0, 0, 6'd0);
        chk("t5_idx_7", 64'(last_i1), 64'd7);
        tick();
        tick();
        tick();
        chk("t5_not_empty", 64'(empty), 64'd0);
        chk("t5_no_retire", 64'(retire_count), 64'd0);
        push(bit_of(50), 2'd1);
        comp(1, 4'd7, 0, 4'd0);
        tick();
        chk("t5_empty", 64'(empty), 64'd1);
`ifdef ROB_RETIRE_CNT_EN
        chk("t5_total", 64'(retired_total), 64'(exp_total));
`endif
        // reset discards six done entries without freeing them
        alloc(1, 1, 6'd1, 1, 1, 6'd2);
        alloc(1, 1, 6'd3, 1, 1, 6'd4);
        alloc(1, 1, 6'd5, 1, 1, 6'd6);
        comp(1, 4'd9, 1, 4'd10);
        comp(1, 4'd11, 1, 4'd12);
        comp(1, 4'd13, 0, 4'd0);
        chk("t6_held", 64'(retire_count), 64'd0);
        comp(1, 4'd8, 0, 4'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_free_regs", free_regs, 64'd0);
        chk("t6_retire_count", 64'(retire_count), 64'd0);
        chk("t6_empty", 64'(empty), 64'd1);
`ifdef ROB_RETIRE_CNT_EN
        chk("t6_total", 64'(retired_total), 64'd0);
`endif
        tick();
        tick();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer sitting directly downstream of the dual-issue rename stage. It accepts up to two renamed instructions per cycle, tracks their completion from the functional units, and retires up to two per cycle in program order. On retirement it returns each instruction's previous physical destination (`oldrd`) to the rename free pool through the one-hot `free_regs` mask.

## Interface
- `DEPTH`, 16: entry count; power of two, ≥4.
- `PREG_W`, 6: physical register index width (64 physical registers).
- `IDX_W`, $clog2(DEPTH): entry tag width.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `alloc_valid_1`, `alloc_valid_2`  in  1  allocate slot 1 / slot 2 this cycle.
- `alloc_has_rd_1`, `alloc_has_rd_2`  in  1  instruction writes a register (0 for SW and unknown opcodes).
- `alloc_oldrd_1`, `alloc_oldrd_2`  in  PREG_W  previous mapping of rd, from rename.
- `alloc_ready`  out  1  at least 2 free entries.
- `alloc_idx_1`, `alloc_idx_2`  out  IDX_W  tags assigned to slot 1 / slot 2 (combinational).
- `complete_valid_a`, `complete_valid_b`  in  1  functional-unit completion strobes.
- `complete_idx_a`, `complete_idx_b`  in  IDX_W  tags being completed.
- `free_regs`  out  64  one-hot mask of freed physical registers; single-cycle pulse.
- `retire_count`  out  2  instructions retired (0–2), aligned with `free_regs`.
- `empty`, `full`  out  1  count==0 / count==DEPTH.

## Operation
- State: `head`, `tail` (IDX_W, wrap modulo DEPTH); `count` (IDX_W+1); per entry `valid`, `done`, `has_rd`, `oldrd`.
- `alloc_ready = (DEPTH - count) >= 2`, computed from the registered `count` only.
- Allocation happens only when `alloc_ready`=1. When `alloc_ready`=0, alloc strobes are ignored; upstream must stall.
  - Slot 1 is written at `tail` when `alloc_valid_1`=1.
  - Slot 2 is written at `tail + alloc_valid_1` when `alloc_valid_2`=1.
  - `tail` advances by `alloc_valid_1 + alloc_valid_2`.
  - `alloc_idx_1 = tail`, `alloc_idx_2 = tail + alloc_valid_1`.
  - A newly written entry gets valid=1, done=0.
- Completion: `done[idx]` is set at the clock edge if `valid[idx]` was 1 at the start of the cycle. Completion to an invalid entry is ignored. Both ports may name the same tag.
- Retire decision is combinational from registered state:
  - r0 = `valid[head] & done[head]`.
  - r1 = r0 & `valid[head+1] & done[head+1]`.
  - Each retired entry is cleared and `head` advances by r0+r1.
- `free_regs` (registered):
  - Set bit `oldrd` for each retired entry with has_rd=1 and oldrd≠0. Physical register 0 is never freed.
  - All other bits are 0. The register is reloaded every cycle, so each value lasts one cycle.
- `count` next = count + allocs − retires. Simultaneous alloc and retire are legal, including at `full` (allocation is blocked by `alloc_ready`, retire proceeds).

## Timing
- Reset: head=tail=count=0, all valid/done=0, `free_regs`=0, `retire_count`=0, `empty`=1, `full`=0, `alloc_ready`=1.
- Reset mid-operation discards all entries; nothing is freed.
- Alloc in cycle N: entry valid in N+1; earliest completion is accepted in N+1.
- Completion in cycle N: done visible in N+1; retire decided in N+1; `free_regs` and `retire_count` asserted in N+2. Minimum complete-to-free latency is 2 cycles.
- Out-of-order completion: a done entry behind an undone head waits. Retire never skips.
- Wrap: `head+1` and all tags are taken modulo DEPTH; entry DEPTH−1 followed by entry 0 retires as a pair.

## Configuration
- `ROB_RETIRE_CNT_EN` defined: adds output `retired_total` (32-bit). It resets to 0, increments by `retire_count`'s source (r0+r1) each cycle, and wraps modulo 2^32.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then alloc slot1 (has_rd=1, oldrd=5) and slot2 (has_rd=1, oldrd=9) -> `alloc_idx_1`=0, `alloc_idx_2`=1. Complete both next cycle -> two cycles later `free_regs` has bits 5 and 9 set, `retire_count`=2, `empty`=1.
- Alloc SW (has_rd=0, oldrd=0) and ADD (oldrd=12); complete tag 1 only -> nothing retires. Then complete tag 0 -> `retire_count`=2, `free_regs` = bit 12 only.
- Fill to count=15 -> `alloc_ready`=0. Assert alloc_valid_1 -> ignored, `tail` unchanged. Retire 2 with simultaneous alloc blocked -> count=13, `alloc_ready`=1.
- Drive head/tail to 14: alloc 4 entries (tags 14, 15, 0, 1), complete all -> retires in pairs (14,15) then (0,1), freed oldrd in that order.
- Complete an unallocated tag 7 while empty, then allocate into tag 7 -> entry done=0, no retire until a fresh completion.
- Reset asserted with 6 valid done entries -> next cycle `free_regs`=0, `retire_count`=0, `empty`=1; with `ROB_RETIRE_CNT_EN`, `retired_total`=0.
